// File: rtl/opb_register_simulink2ppc_hs_pkg.sv
// Shared constants for the Simulink-to-PPC OPB register: register offsets,
// STATUS/CTRL bit positions and the bus-slave FSM state type.
package opb_s2p_pkg;

  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  localparam int ST_VALID   = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_CNT_LSB = 16;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_DROP    = 1;

  localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } slv_state_e;

endpackage

// File: rtl/opb_register_simulink2ppc_hs_if.sv
// OPB bus bundle between the PPC-side master and the register slave.
//
// Handshake: the master raises OPB_select with address/RNW/BE/data stable and
// holds them until it sees Sl_xferAck for exactly one cycle, then drops
// OPB_select; the slave acks once per select assertion. The fabric side
// (user_valid/user_ready, plain ports on the slave) transfers a word on every
// cycle where both are high.
interface opb_s2p_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_hs_slave_if.sv
// OPB slave front end: window decode and IDLE/ACK/WAIT FSM. Emits one-cycle
// read/write strobes with the registered offset, byte enables and write data.
module opb_slave_if
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01003100,
  parameter logic [31:0] C_HIGHADDR = 32'h010031FF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] abus_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] dbus_i,
  input  logic        rnw_i,
  input  logic        select_i,
  output logic        ack_o,
  output logic        rd_stb_o,
  output logic        wr_stb_o,
  output logic [7:0]  offset_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output slv_state_e  state_o
);

  slv_state_e  state_q, state_d;
  logic [7:0]  offset_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        rnw_q;
  logic        hit;

  assign hit = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // WAIT holds until select drops so a held select never earns a second ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!select_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o    = (state_q == S_ACK);
    rd_stb_o = (state_q == S_ACK) && rnw_q;
    wr_stb_o = (state_q == S_ACK) && !rnw_q;
    offset_o = offset_q;
    be_o     = be_q;
    wdata_o  = wdata_q;
    state_o  = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rnw_q    <= 1'b0;
    end else if ((state_q == S_IDLE) && hit) begin
      offset_q <= abus_i[7:0] - C_BASEADDR[7:0];
      be_q     <= be_i;
      wdata_q  <= dbus_i;
      rnw_q    <= rnw_i;
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_hs.sv
// Simulink-to-PPC return register: holds one fabric word until the PPC reads
// DATA. Optional 16-bit overflow counter enabled by SIMULINK2PPC_OVF_CNT_EN.
module opb_register_simulink2ppc_hs
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01003100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010031FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  opb_s2p_if.slave    opb,
  input  logic [31:0] user_data_in,
  input  logic        user_valid,
  output logic        user_ready,
  output slv_state_e  dbg_state_o
);

  logic        ack, rd_stb, wr_stb;
  logic [7:0]  offset;
  logic [3:0]  be;
  logic [31:0] wdata;

  // Bus vectors are [0:31]; plain assignment keeps the numeric value, so
  // BE[3] (LSB byte lane) lands in be[0].
  logic [31:0] abus_n, dbus_n;
  logic [3:0]  be_n;
  assign abus_n = opb.OPB_ABus;
  assign dbus_n = opb.OPB_DBus;
  assign be_n   = opb.OPB_BE;

  opb_slave_if #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_slave (
    .clk_i    (OPB_Clk),
    .rst_ni   (OPB_Rst_n),
    .abus_i   (abus_n),
    .be_i     (be_n),
    .dbus_i   (dbus_n),
    .rnw_i    (opb.OPB_RNW),
    .select_i (opb.OPB_select),
    .ack_o    (ack),
    .rd_stb_o (rd_stb),
    .wr_stb_o (wr_stb),
    .offset_o (offset),
    .be_o     (be),
    .wdata_o  (wdata),
    .state_o  (dbg_state_o)
  );

  logic [31:0] snapshot_q, snapshot_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic [15:0] ovf_cnt;
  logic        pop, ctrl_wr, clr, drop, free, capture, overflow;

  always_comb begin
    pop      = rd_stb && (offset == OFF_DATA);
    ctrl_wr  = wr_stb && (offset == OFF_CTRL) && be[0];
    clr      = ctrl_wr && wdata[CTRL_CLR_OVF];
    drop     = ctrl_wr && wdata[CTRL_DROP];
    // A slot freed this cycle (read or drop) takes the incoming word.
    free     = !valid_q || pop || drop;
    capture  = user_valid && free;
    overflow = user_valid && !free;
  end

  always_comb begin
    snapshot_d = snapshot_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    if (pop || drop) valid_d = 1'b0;
    if (capture) begin
      snapshot_d = user_data_in;
      valid_d    = 1'b1;
    end
    if (overflow) ovf_d = 1'b1;
    if (clr)      ovf_d = 1'b0;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      snapshot_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      snapshot_q <= snapshot_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SIMULINK2PPC_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (overflow && (ovf_cnt_q != OVF_CNT_MAX)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    if (clr) ovf_cnt_d = '0;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = '0;
`endif

  logic [31:0] status, rdata;

  always_comb begin
    status                         = '0;
    status[ST_VALID]               = valid_q;
    status[ST_OVF]                 = ovf_q;
    status[ST_CNT_LSB +: 16]       = ovf_cnt;
    rdata = '0;
    // OR-bus: drive zero except during the ack of a read.
    if (rd_stb) begin
      case (offset)
        OFF_DATA:   rdata = snapshot_q;
        OFF_STATUS: rdata = status;
        default:    rdata = '0;
      endcase
    end
  end

  assign opb.Sl_DBus    = rdata;
  assign opb.Sl_xferAck = ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign user_ready     = !valid_q;

  logic unused_bits;
  assign unused_bits = ^{be[3:1], wdata[31:2], opb.OPB_seqAddr};

endmodule

// File: tb/tb_opb_register_simulink2ppc_hs.sv
// Directed bench for opb_register_simulink2ppc_hs: transaction-level model of
// the holding register plus per-cycle bus/ready checks.
module tb_opb_register_simulink2ppc_hs;
  import opb_s2p_pkg::*;

  localparam logic [31:0] BASE = 32'h01003100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  opb_s2p_if bus ();
  logic [31:0] user_data;
  logic        user_valid;
  logic        user_ready;
  slv_state_e  dbg_state;

  opb_register_simulink2ppc_hs dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .opb          (bus.slave),
    .user_data_in (user_data),
    .user_valid   (user_valid),
    .user_ready   (user_ready),
    .dbg_state_o  (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_snap  = '0;
  bit          m_valid = 1'b0;
  bit          m_ovf   = 1'b0;
  int          m_cnt   = 0;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = {30'd0, m_ovf, m_valid};
`ifdef SIMULINK2PPC_OVF_CNT_EN
    s[31:16] = m_cnt[15:0];
`endif
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] off);
    if (off == 8'h00) return m_snap;
    if (off == 8'h04) return m_status();
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_snap = '0; m_valid = 1'b0; m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic m_offer(input logic [31:0] w);
    if (!m_valid) begin
      m_snap = w; m_valid = 1'b1;
    end else begin
      m_ovf = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic m_bus_effect(input logic [31:0] addr, input bit rnw,
                              input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] off;
    off = addr - BASE;
    if (rnw && off == 32'h0) m_valid = 1'b0;
    if (!rnw && off == 32'h8 && be[0]) begin
      if (wd[0]) begin m_ovf = 1'b0; m_cnt = 0; end
      if (wd[1]) m_valid = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("user_ready", {31'd0, user_ready}, {31'd0, !m_valid});
      if (!bus.Sl_xferAck) check("dbus_idle_zero", bus.Sl_DBus, 32'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic offer(input logic [31:0] w);
    @(posedge clk); #1;
    user_valid = 1'b1; user_data = w;
    @(posedge clk); #1;
    user_valid = 1'b0;
    m_offer(w);
  endtask

  task automatic xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output int nacks, output int lat);
    rd = '0; nacks = 0; lat = 0;
    @(posedge clk); #1;
    bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_BE = be;
    bus.OPB_DBus = rnw ? 32'd0 : wd; bus.OPB_select = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (bus.Sl_xferAck) begin
        nacks++;
        if (lat == 0) begin lat = i; rd = bus.Sl_DBus; end
      end
      if (i < hold) @(posedge clk);
    end
    @(posedge clk); #1;
    bus.OPB_select = 1'b0;
    if (nacks > 0) m_bus_effect(addr, rnw, wd, be);
    @(negedge clk);
    if (bus.Sl_xferAck) nacks++;
  endtask

  task automatic rd_exp(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd; int n, l;
    xfer(BASE + {24'd0, off}, 1'b1, 32'd0, 4'hF, 2, rd, n, l);
    check({name, "_acks"}, n, 1);
    check({name, "_latency"}, l, 2);
    check(name, rd, exp);
  endtask

  task automatic rd_model(input string name, input logic [7:0] off);
    rd_exp(name, off, m_read(off));
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [31:0] wd,
                    input logic [3:0] be);
    logic [31:0] rd; int n, l;
    xfer(BASE + {24'd0, off}, 1'b0, wd, be, 2, rd, n, l);
    check({name, "_acks"}, n, 1);
  endtask

  task automatic rd_data_coincident(input logic [31:0] w);
    logic [31:0] exp;
    exp = m_snap;
    @(posedge clk); #1;
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    user_valid = 1'b1; user_data = w;
    @(negedge clk);
    check("coinc_ack", {31'd0, bus.Sl_xferAck}, 32'd1);
    check("coinc_data", bus.Sl_DBus, exp);
    @(posedge clk); #1;
    user_valid = 1'b0; bus.OPB_select = 1'b0;
    m_valid = 1'b0;
    m_offer(w);
    @(negedge clk);
    check("coinc_no_second_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd; int n, l;
    logic [31:0] st_ovf3, st_ovf3_popped;
`ifdef SIMULINK2PPC_OVF_CNT_EN
    st_ovf3 = 32'h00030003; st_ovf3_popped = 32'h00030002;
`else
    st_ovf3 = 32'h00000003; st_ovf3_popped = 32'h00000002;
`endif
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
    bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    user_data = '0; user_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, user_ready}, 32'd1);
    check("rst_ack", {31'd0, bus.Sl_xferAck}, 32'd0);
    check("rst_dbus", bus.Sl_DBus, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: basic read after reset
    rd_exp("t1_status", 8'h04, 32'h0);

    // 2: capture and pop
    offer(32'hDEADBEEF);
    rd_exp("t2_status", 8'h04, 32'h1);
    rd_exp("t2_data", 8'h00, 32'hDEADBEEF);
    rd_exp("t2_status_after", 8'h04, 32'h0);
    rd_exp("t2_stale_data", 8'h00, 32'hDEADBEEF);
    rd_model("t2_status_model", 8'h04);

    // 3: overflow, sticky bit, clear
    offer(32'h1);
    repeat (3) offer(32'h2);
    rd_exp("t3_status_ovf", 8'h04, st_ovf3);
    rd_exp("t3_data", 8'h00, 32'h1);
    rd_exp("t3_status_popped", 8'h04, st_ovf3_popped);
    wr("t3_ctrl_no_be", 8'h08, 32'h1, 4'hE);
    rd_model("t3_status_be_ignored", 8'h04);
    wr("t3_ctrl_clr", 8'h08, 32'h1, 4'hF);
    rd_exp("t3_status_cleared", 8'h04, 32'h0);

    // CTRL drop, write to read-only DATA ignored
    offer(32'h11);
    wr("drop", 8'h08, 32'h2, 4'hF);
    rd_exp("drop_status", 8'h04, 32'h0);
    offer(32'h22);
    wr("wr_data_ro", 8'h00, 32'h12345678, 4'hF);
    rd_exp("wr_ro_data", 8'h00, 32'h22);
    rd_model("wr_ro_status", 8'h04);

    // 4: pop coincident with new word
    offer(32'h33);
    rd_data_coincident(32'hA5A5A5A5);
    rd_exp("t4_status", 8'h04, 32'h1);
    rd_exp("t4_data", 8'h00, 32'hA5A5A5A5);

    // 5: held select, unmapped offset, out of window
    xfer(BASE + 32'h4, 1'b1, 32'd0, 4'hF, 4, rd, n, l);
    check("t5_held_acks", n, 1);
    check("t5_held_data", rd, 32'h0);
    rd_exp("t5_off40", 8'h40, 32'h0);
    xfer(32'h01003200, 1'b1, 32'd0, 4'hF, 3, rd, n, l);
    check("t5_above_window_acks", n, 0);
    xfer(32'h010030FC, 1'b1, 32'd0, 4'hF, 3, rd, n, l);
    check("t5_below_window_acks", n, 0);
    rd_exp("t5_last_byte", 8'hFC, 32'h0);

    // 6: reset during ACK
    offer(32'h77);
    offer(32'h78);
    @(posedge clk); #1;
    bus.OPB_ABus = BASE + 32'h4; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_ack_before_rst", {31'd0, bus.Sl_xferAck}, 32'd1);
    #1;
    rst_n = 1'b0;
    bus.OPB_select = 1'b0;
    m_reset();
    #1;
    check("t6_ack_in_rst", {31'd0, bus.Sl_xferAck}, 32'd0);
    check("t6_dbus_in_rst", bus.Sl_DBus, 32'd0);
    check("t6_state_in_rst", {30'd0, dbg_state}, {30'd0, S_IDLE});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_exp("t6_status", 8'h04, 32'h0);
    rd_exp("t6_data", 8'h00, 32'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
